// File: rtl/counter_sequencer.sv
// Purpose: takes one (start, target, dir) command and steps an attached up_down_counter from start to target.
// Latency: accept edge, then 1 LOAD cycle, k+1 RUN cycles and 1 DONE cycle, where k is the wrap-around distance.
// Backpressure: cmd_ready is high only in IDLE; a command offered in any other state waits until IDLE.
module counter_sequencer #(
    parameter int N       = 4,
    parameter int MAX_CYC = 20
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [N-1:0] cmd_start,
    input  logic [N-1:0] cmd_target,
    input  logic         cmd_dir,
    input  logic         abort,
    input  logic [N-1:0] cnt_out,
    output logic         load,
    output logic         enable,
    output logic         s,
    output logic [N-1:0] in,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [N-1:0] steps
);

    localparam int TW = $clog2(MAX_CYC + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [N-1:0]  start_q;
    logic [N-1:0]  target_q;
    logic          dir_q;
    logic [N-1:0]  steps_q;
    logic [TW-1:0] timer_q;
    logic          err_q;
    logic          at_target;
    logic          timeout;

    // The counter output is registered, so comparing it against the target
    // tells us whether the previous enable already landed on the target.
    assign at_target = (cnt_out == target_q);
    // Timer counts enabled RUN cycles; once it holds MAX_CYC we give up.
    assign timeout   = (timer_q == TW'(MAX_CYC));
    assign steps     = steps_q;

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Command, step counter, timer and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            start_q  <= '0;
            target_q <= '0;
            dir_q    <= 1'b0;
            steps_q  <= '0;
            timer_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        start_q  <= cmd_start;
                        target_q <= cmd_target;
                        dir_q    <= cmd_dir;
                        steps_q  <= '0;
                        timer_q  <= '0;
                        err_q    <= 1'b0;
                    end
                end
                RUN: begin
                    // An aborted cycle is not counted; steps keeps the partial count.
                    if (!abort) begin
                        if (at_target) begin
                            err_q <= 1'b0;
                        end else if (timeout) begin
                            err_q <= 1'b1;
                        end else begin
                            steps_q <= steps_q + N'(1);
                            timer_q <= timer_q + TW'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (cmd_valid) state_nxt = LOAD;
            LOAD: state_nxt = abort ? IDLE : RUN;
            RUN: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (at_target || timeout) begin
                    state_nxt = DONE;
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode from state and registers; enable also looks at cnt_out.
    always_comb begin
        cmd_ready = 1'b0;
        load      = 1'b0;
        enable    = 1'b0;
        s         = 1'b0;
        in        = '0;
        busy      = (state != IDLE);
        done      = 1'b0;
        err       = 1'b0;
        case (state)
            IDLE: cmd_ready = 1'b1;
            LOAD: begin
                load = 1'b1;
                in   = start_q;
                s    = dir_q;
            end
            RUN: begin
                s      = dir_q;
                enable = !at_target && !timeout;
            end
            DONE: begin
                done = 1'b1;
                err  = err_q;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer driving a behavioural up/down counter.
// Inputs change and outputs are sampled on the falling clock edge.
// Each scenario task checks its own expected values inline.
module tb_counter_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [3:0] cmd_start = '0;
    logic [3:0] cmd_target = '0;
    logic       cmd_dir = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] cnt_out;
    logic       load, enable, s, busy, done, err;
    logic [3:0] in, steps;

    logic       stuck = 1'b0;
    logic [3:0] cnt_q;

    int total = 0;
    int bad = 0;

    int         n_load, n_en, n_run, done_at;
    logic       err_v, overlap, s_bad;
    logic [3:0] steps_v;
    logic [3:0] trace[$];

    counter_sequencer #(.N(4), .MAX_CYC(20)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_start(cmd_start), .cmd_target(cmd_target), .cmd_dir(cmd_dir),
        .abort(abort), .cnt_out(cnt_out),
        .load(load), .enable(enable), .s(s), .in(in),
        .busy(busy), .done(done), .err(err), .steps(steps)
    );

    always #5 clk = ~clk;

    // Behavioural up_down_counter: load beats enable, wraps mod 16.
    always_ff @(posedge clk) begin
        if (!rst_n)      cnt_q <= 4'd0;
        else if (load)   cnt_q <= in;
        else if (enable) cnt_q <= s ? cnt_q - 4'd1 : cnt_q + 4'd1;
    end
    assign cnt_out = stuck ? 4'd0 : cnt_q;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input logic [3:0] st, input logic [3:0] tg, input logic d);
        cmd_valid  = 1'b1;
        cmd_start  = st;
        cmd_target = tg;
        cmd_dir    = d;
        step();
        cmd_valid  = 1'b0;
    endtask

    // Walk from the LOAD cycle to DONE (bounded), recording what was seen.
    task automatic observe(input logic exp_s);
        n_load = 0; n_en = 0; n_run = 0; done_at = -1;
        err_v = 1'b0; steps_v = '0; overlap = 1'b0; s_bad = 1'b0;
        trace.delete();
        for (int i = 0; i < 100; i++) begin
            if (load) n_load++;
            if (enable) n_en++;
            if (load && enable) overlap = 1'b1;
            if (busy && !done && s !== exp_s) s_bad = 1'b1;
            if (busy && !load && !done) begin
                n_run++;
                trace.push_back(cnt_out);
            end
            if (done) begin
                done_at = i; err_v = err; steps_v = steps;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(); step();
        total++;
        if ({load, enable, done, err, s, busy} !== 6'b0 || in !== 4'd0 || steps !== 4'd0 || cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_outputs got load=%0b en=%0b done=%0b err=%0b s=%0b busy=%0b in=%0d steps=%0d rdy=%0b want all 0 rdy=1",
                     load, enable, done, err, s, busy, in, steps, cmd_ready);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_up();
        logic ok;
        issue(4'd3, 4'd9, 1'b0);
        total++;
        if (load !== 1'b1 || in !== 4'd3 || enable !== 1'b0) begin
            bad++; $display("FAIL up_load got load=%0b in=%0d en=%0b want 1 3 0", load, in, enable);
        end
        observe(1'b0);
        total++;
        if (n_load !== 1 || overlap !== 1'b0) begin
            bad++; $display("FAIL up_load_pulses got %0d overlap=%0b want 1 0", n_load, overlap);
        end
        ok = (trace.size() == 7);
        for (int i = 0; i < trace.size() && ok; i++) if (trace[i] !== 4'(3 + i)) ok = 1'b0;
        total++;
        if (!ok) begin bad++; $display("FAIL up_trace got %p want 3..9", trace); end
        total++;
        if (done_at !== 8 || err_v !== 1'b0 || steps_v !== 4'd6) begin
            bad++; $display("FAIL up_done got at=%0d err=%0b steps=%0d want 8 0 6", done_at, err_v, steps_v);
        end
        step();
        total++;
        if (cmd_ready !== 1'b1 || done !== 1'b0 || steps !== 4'd6) begin
            bad++; $display("FAIL up_idle got rdy=%0b done=%0b steps=%0d want 1 0 6", cmd_ready, done, steps);
        end
    endtask

    task automatic test_down_wrap();
        logic ok;
        logic [3:0] v;
        issue(4'd3, 4'd9, 1'b1);
        observe(1'b1);
        ok = (trace.size() == 11);
        v = 4'd3;
        for (int i = 0; i < trace.size() && ok; i++) begin
            if (trace[i] !== v) ok = 1'b0;
            v = v - 4'd1;
        end
        total++;
        if (!ok) begin bad++; $display("FAIL down_trace got %p want 3,2,1,0,15..9", trace); end
        total++;
        if (s_bad !== 1'b0 || overlap !== 1'b0) begin
            bad++; $display("FAIL down_s got s_bad=%0b overlap=%0b want 0 0", s_bad, overlap);
        end
        total++;
        if (done_at !== 12 || err_v !== 1'b0 || steps_v !== 4'd10) begin
            bad++; $display("FAIL down_done got at=%0d err=%0b steps=%0d want 12 0 10", done_at, err_v, steps_v);
        end
        step();
    endtask

    task automatic test_zero_distance();
        issue(4'd5, 4'd5, 1'b0);
        observe(1'b0);
        total++;
        if (n_load !== 1 || n_en !== 0) begin
            bad++; $display("FAIL zero_ctrl got loads=%0d enables=%0d want 1 0", n_load, n_en);
        end
        total++;
        if (done_at !== 2 || err_v !== 1'b0 || steps_v !== 4'd0) begin
            bad++; $display("FAIL zero_done got at=%0d err=%0b steps=%0d want 2 0 0", done_at, err_v, steps_v);
        end
        step();
    endtask

    task automatic test_timeout();
        logic en_seen;
        stuck = 1'b1;
        issue(4'd2, 4'd7, 1'b0);
        observe(1'b0);
        total++;
        if (n_run !== 21 || n_en !== 20) begin
            bad++; $display("FAIL tmo_cycles got run=%0d en=%0d want 21 20", n_run, n_en);
        end
        total++;
        if (done_at !== 22 || err_v !== 1'b1 || steps_v !== 4'd4) begin
            bad++; $display("FAIL tmo_done got at=%0d err=%0b steps=%0d want 22 1 4", done_at, err_v, steps_v);
        end
        en_seen = enable;
        for (int i = 0; i < 3; i++) begin
            step();
            if (enable) en_seen = 1'b1;
        end
        total++;
        if (en_seen !== 1'b0) begin bad++; $display("FAIL tmo_enable_after got %0b want 0", en_seen); end
        stuck = 1'b0;
    endtask

    task automatic test_abort();
        logic done_seen;
        issue(4'd0, 4'd12, 1'b0);
        for (int i = 0; i < 5; i++) step();
        total++;
        if (steps !== 4'd4 || busy !== 1'b1) begin
            bad++; $display("FAIL abort_pre got steps=%0d busy=%0b want 4 1", steps, busy);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        total++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0 || load !== 1'b0 || enable !== 1'b0 || steps !== 4'd4) begin
            bad++; $display("FAIL abort_idle got busy=%0b rdy=%0b done=%0b load=%0b en=%0b steps=%0d want 0 1 0 0 0 4",
                            busy, cmd_ready, done, load, enable, steps);
        end
        done_seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (done) done_seen = 1'b1;
        end
        total++;
        if (done_seen !== 1'b0) begin bad++; $display("FAIL abort_no_done got %0b want 0", done_seen); end
        issue(4'd1, 4'd4, 1'b0);
        observe(1'b0);
        total++;
        if (done_at !== 5 || err_v !== 1'b0 || steps_v !== 4'd3) begin
            bad++; $display("FAIL abort_next got at=%0d err=%0b steps=%0d want 5 0 3", done_at, err_v, steps_v);
        end
        step();
    endtask

    task automatic test_reset_mid_run();
        issue(4'd0, 4'd10, 1'b0);
        step(); step(); step();
        rst_n = 1'b0;
        step();
        total++;
        if ({load, enable, done, err, s, busy} !== 6'b0 || in !== 4'd0 || steps !== 4'd0 || cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_run got load=%0b en=%0b done=%0b err=%0b s=%0b busy=%0b in=%0d steps=%0d rdy=%0b want all 0 rdy=1",
                     load, enable, done, err, s, busy, in, steps, cmd_ready);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        issue(4'd6, 4'd6, 1'b0);
        step(); step();
        cmd_valid = 1'b1; cmd_start = 4'd1; cmd_target = 4'd2; cmd_dir = 1'b0;
        total++;
        if (done !== 1'b1 || cmd_ready !== 1'b0) begin
            bad++; $display("FAIL b2b_done got done=%0b rdy=%0b want 1 0", done, cmd_ready);
        end
        step();
        total++;
        if (busy !== 1'b0 || load !== 1'b0 || cmd_ready !== 1'b1) begin
            bad++; $display("FAIL b2b_idle got busy=%0b load=%0b rdy=%0b want 0 0 1", busy, load, cmd_ready);
        end
        step();
        cmd_valid = 1'b0;
        total++;
        if (load !== 1'b1 || in !== 4'd1) begin
            bad++; $display("FAIL b2b_load got load=%0b in=%0d want 1 1", load, in);
        end
        observe(1'b0);
        total++;
        if (done_at !== 3 || err_v !== 1'b0 || steps_v !== 4'd1) begin
            bad++; $display("FAIL b2b_result got at=%0d err=%0b steps=%0d want 3 0 1", done_at, err_v, steps_v);
        end
        step();
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_up();
        test_down_wrap();
        test_zero_distance();
        test_timeout();
        test_abort();
        test_reset_mid_run();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
